// File: rtl/nibble_serial_subtractor.sv
// ---------------------------------------------------------------------------
// nibble_serial_subtractor
//   Multi-cycle subtractor: Diff = a - b - bin (modulo 2^WIDTH).
//   One SLICE-bit slice is processed per clock, least-significant first,
//   by adding a to the inverted b through a registered carry.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   start    request, sampled only when busy=0 (IDLE or DONE)
//   a, b     minuend / subtrahend, captured when start is accepted
//   bin      borrow in, captured with a and b
//   busy     high while an operation is in flight (state RUN)
//   done     one-cycle pulse when results are valid
//   Diff     result, a - b - bin modulo 2^WIDTH
//   Bout     borrow out of the MSB
//   Ovf      two's-complement signed overflow
//   Zero     Diff == 0
// ---------------------------------------------------------------------------
module nibble_serial_subtractor #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Ovf,
  output logic             Zero
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   res_q;
  logic               carry_q;
  logic [CW-1:0]      cnt_q;
  logic               a_msb_q;
  logic               b_msb_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   diff_q;
  logic               bout_q;
  logic               ovf_q;
  logic               zero_q;

  logic [SLICE-1:0]   b_inv;
  logic [SLICE:0]     slice_sum;
  logic [WIDTH-1:0]   res_d;
  logic               accept;

  // Start is only honoured when not busy (IDLE, or the DONE cycle for
  // back-to-back operation).
  assign accept = start && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    b_inv     = ~b_q[SLICE-1:0];
    slice_sum = {1'b0, a_q[SLICE-1:0]} + {1'b0, b_inv} + {{SLICE{1'b0}}, carry_q};
    // New slice enters at the top; after NSLICE shifts the LSB slice has
    // arrived at bit 0 and res_d holds the full difference.
    res_d     = (res_q >> SLICE) | (WIDTH'(slice_sum[SLICE-1:0]) << (WIDTH - SLICE));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        a_q     <= a;
        b_q     <= b;
        a_msb_q <= a[WIDTH-1];
        b_msb_q <= b[WIDTH-1];
        // a - b - bin == a + ~b + ~bin
        carry_q <= ~bin;
        cnt_q   <= '0;
        state_q <= RUN;
        busy_q  <= 1'b1;
      end else begin
        case (state_q)
          RUN: begin
            a_q     <= a_q >> SLICE;
            b_q     <= b_q >> SLICE;
            res_q   <= res_d;
            carry_q <= slice_sum[SLICE];
            cnt_q   <= cnt_q + CW'(1);
            if (cnt_q == LAST_CNT) begin
              cnt_q   <= '0;
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              diff_q  <= res_d;
              bout_q  <= ~slice_sum[SLICE];
              ovf_q   <= (a_msb_q != b_msb_q) && (res_d[WIDTH-1] != a_msb_q);
              zero_q  <= (res_d == '0);
            end
          end
          DONE: begin
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Diff = diff_q;
  assign Bout = bout_q;
  assign Ovf  = ovf_q;
  assign Zero = zero_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_nibble_serial_subtractor
//   Directed-vector bench with a scoreboard. The driver pushes the
//   hand-computed result and the cycle in which done must appear; the
//   monitor pops and compares whenever done is seen.
// ---------------------------------------------------------------------------
module tb_nibble_serial_subtractor;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        busy;
  logic        done;
  logic [15:0] Diff;
  logic        Bout;
  logic        Ovf;
  logic        Zero;

  typedef struct {
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  nibble_serial_subtractor #(.WIDTH(16), .SLICE(4)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .bin    (bin),
    .busy   (busy),
    .done   (done),
    .Diff   (Diff),
    .Bout   (Bout),
    .Ovf    (Ovf),
    .Zero   (Zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: 0x%0h (cycle %0d)", name, act, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending result (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("done_cycle", cyc,    e.cyc);
        check("Diff",       Diff,   e.diff);
        check("Bout",       Bout,   e.bout);
        check("Ovf",        Ovf,    e.ovf);
        check("Zero",       Zero,   e.zero);
        check("busy_in_done", busy, 1'b0);
      end
    end
  end

  // Drive start with operands; called just after a rising edge while the
  // DUT can accept. Returns 1 time unit after the accepting edge, with
  // inputs scrambled to show they are no longer used.
  task automatic issue(input logic [15:0] ta, input logic [15:0] tb_, input logic tbin,
                       input logic [15:0] ed, input logic eb, input logic eo, input logic ez);
    a     = ta;
    b     = tb_;
    bin   = tbin;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    q.push_back('{ed, eb, eo, ez, cyc + 4});
    a   = 16'hA5C3;
    b   = 16'h3C5A;
    bin = ~tbin;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    a       = '0;
    b       = '0;
    bin     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_Diff", Diff, 16'h0000);
    check("rst_Bout", Bout, 1'b0);
    check("rst_Ovf",  Ovf,  1'b0);
    check("rst_Zero", Zero, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic operation plus busy profile: busy for 4 cycles, then done.
    issue(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      check("busy_run", busy, 1'b1);
      @(posedge clk);
      #1;
    end
    check("busy_after_run", busy, 1'b0);
    @(posedge clk);
    #1;

    issue(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    issue(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    issue(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #1;

    // Zero result, then results must hold through idle cycles.
    issue(16'h0005, 16'h0004, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    for (int k = 0; k < 10; k++) begin
      check("hold_Diff", Diff, 16'h0000);
      check("hold_Zero", Zero, 1'b1);
      check("hold_Bout", Bout, 1'b0);
      check("hold_Ovf",  Ovf,  1'b0);
      @(posedge clk);
      #1;
    end

    // Start while busy is ignored; start during DONE is accepted.
    issue(16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    a     = 16'h1111;
    b     = 16'h0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_ignored_start", busy, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("done_b2b", done, 1'b1);
    issue(16'h0010, 16'h0020, 1'b0, 16'hFFF0, 1'b1, 1'b0, 1'b0);
    check("busy_b2b", busy, 1'b1);
    repeat (5) @(posedge clk);
    #1;

    // Asynchronous reset in the second RUN cycle aborts the operation.
    issue(16'h1234, 16'h0001, 1'b0, 16'h1233, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    q.delete();
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_Diff", Diff, 16'h0000);
    check("abort_Bout", Bout, 1'b0);
    check("abort_Ovf",  Ovf,  1'b0);
    check("abort_Zero", Zero, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("post_abort_busy", busy, 1'b0);
    issue(16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;

    // Drain: every expected result must have been seen.
    for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
    check("queue_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nibble_serial_subtractor.md
Name: nibble_serial_subtractor

Overview:
- Multi-cycle WIDTH-bit subtractor for the ALU datapath: computes Diff = a - b - bin.
- Processes one SLICE-bit nibble per clock, least-significant first, using a ripple slice that adds a to the inverted b with a carry chain.
- Trades latency for area against the combinational ripple adder chain.
- Start/busy/done handshake; result and flags are held stable until the next accepted start.

Parameters:
- WIDTH, 16, operand and result width; must be a positive multiple of SLICE.
- SLICE, 4, bits processed per clock cycle.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when busy=0
- a  input  WIDTH  minuend; captured on the cycle start is accepted
- b  input  WIDTH  subtrahend; captured with a
- bin  input  1  borrow in; captured with a
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse when results are valid
- Diff  output  WIDTH  result, a - b - bin, modulo 2^WIDTH
- Bout  output  1  borrow out of the MSB (1 when unsigned a < b + bin)
- Ovf  output  1  two's-complement signed overflow
- Zero  output  1  Diff == 0

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy=0, done=0, Diff=0, Bout=0, Ovf=0, Zero=0; slice counter=0; operand regs=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 captures a, b, bin into internal shift registers.
  - Carry register is set to ~bin; counter=0; next state RUN.
  - start=0 keeps the state in IDLE.
- RUN (busy=1):
  - Each cycle computes slice k: {c, s} = a_k + ~b_k + carry. Here a_k and b_k are the low SLICE bits of the shift registers.
  - s is shifted into the top of the result shift register; a and b shift right by SLICE; carry <= c; counter increments.
  - After WIDTH/SLICE cycles (4 at defaults), the edge that processes the last slice moves the state to DONE.
  - That same edge loads Diff, Bout = ~c_final, Ovf, and Zero.
  - Ovf = (a[MSB] != b[MSB]) && (Diff[MSB] != a[MSB]), using the captured operands.
- DONE:
  - Lasts exactly one cycle: done=1, busy=0.
  - Next state is IDLE, unless start=1 in this cycle. In that case new operands are captured and the next state is RUN (back-to-back operation).
- busy is registered and equals (state==RUN).
- done is high only in DONE.
- Latency: start sampled at edge E0; busy=1 for the cycles after edges E0..E3; done=1 and results valid after edge E4. That is WIDTH/SLICE+1 cycles from start to done.
- Diff, Bout, Ovf and Zero change only on the edge entering DONE. They hold through IDLE, RUN and subsequent operations until the next completion.
- start while busy=1 is ignored; there is no queueing.
- Inputs a, b and bin may change freely after capture without affecting the in-flight result.
- reset_n asserted mid-RUN aborts the operation immediately. All outputs return to their reset values and no done pulse is produced.
- Wrap-around: results are modulo 2^WIDTH; a borrow is reported only via Bout.

Test Plan:
- Reset then a=0x1234, b=0x0234, bin=0, pulse start → done exactly 5 cycles later; Diff=0x1000, Bout=0, Ovf=0, Zero=0; busy high for 4 cycles.
- a=0x0000, b=0x0001, bin=0 → Diff=0xFFFF, Bout=1, Ovf=0, Zero=0.
- a=0x8000, b=0x0001, bin=0 → Diff=0x7FFF, Bout=0, Ovf=1; and a=0x7FFF, b=0xFFFF → Diff=0x8000, Bout=1, Ovf=1.
- a=0x0005, b=0x0004, bin=1 → Diff=0x0000, Zero=1, Bout=0; outputs stay constant for 10 idle cycles afterwards.
- Start a=0x00FF, b=0x000F; pulse start again with different operands 2 cycles later (busy) → second start ignored, Diff=0x00F0. Then assert start during the DONE cycle with a=0x0010, b=0x0020 → busy the next cycle, Diff=0xFFF0, Bout=1 after a further 5 cycles.
- Start an operation, drop reset_n asynchronously in the 2nd RUN cycle → busy, done and all results read 0 immediately; no done pulse after release; a fresh start then completes normally.
